systolic_mm: RTL and testbench

Output-stationary, parametrised ROWS x COLS systolic matrix-multiply engine computing C = A·B for a runtime inner dimension K up to KMAX.
- Accepts one K-slice per beat over a valid/ready stream.
- Skews operands internally and accumulates in a grid of MAC processing elements.
- Drains results one row per beat over a second valid/ready stream.

It is the next-generation compute array: a rectangular grid with handshaking, bubble tolerance, an accumulate/drain sequencer and signed accumulators in place of a free-running square mesh.

---
 rtl/systolic_mm_pkg.sv | 50 +++++
 rtl/systolic_mm_if.sv | 45 ++++
 rtl/mac_pe.sv | 78 +++++++
 rtl/systolic_mm.sv | 237 +++++++++++++++++++++++
 tb/tb_systolic_mm.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_mm_pkg.sv
// systolic_mm_pkg: shared types and helpers for the systolic matrix-multiply engine.
//   state_t        sequencer states (IDLE, LOAD, FLUSH, DRAIN)
//   default_acc_w  accumulator width that holds a full KMAX-deep dot product
//   sat_add        saturating signed add, used by mac_pe when SYSTOLIC_MM_SAT_EN is defined
package systolic_mm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Wide enough to hold the sum of two ACC_W values without overflow.
   localparam int SAT_W = 64;

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    sat;
   } sat_res_t;

   function automatic int default_acc_w(input int width, input int kmax);
      return 2 * width + $clog2(kmax);
   endfunction

   // a and b are sign-extended acc_w-bit values; the result is clamped to the
   // acc_w-bit two's-complement range and sat reports whether clamping happened.
   function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                        input logic signed [SAT_W-1:0] b,
                                        input int acc_w);
      sat_res_t r;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] s;
      hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (acc_w - 1));
      s  = a + b;
      r.sum = s;
      r.sat = 1'b0;
      if (s > hi) begin
         r.sum = hi;
         r.sat = 1'b1;
      end else if (s < lo) begin
         r.sum = lo;
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/systolic_mm_if.sv
// systolic_mm_if: operand and result streams of systolic_mm.
//   in_valid/in_ready/a_data/b_data   operand K-slice stream (one beat per k)
//   c_valid/c_ready/c_data/c_row      result stream (one C row per beat)
//   sat_flag                          sticky saturation flag, only with SYSTOLIC_MM_SAT_EN
// Modports: master = producer/consumer around the engine, slave = the engine.
interface systolic_mm_if
   import systolic_mm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int KMAX  = 256,
   parameter int ACC_W = default_acc_w(WIDTH, KMAX)
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                    in_valid;
   logic                    in_ready;
   logic [ROWS*WIDTH-1:0]   a_data;
   logic [COLS*WIDTH-1:0]   b_data;
   logic [COLS*ACC_W-1:0]   c_data;
   logic [RW-1:0]           c_row;
   logic                    c_valid;
   logic                    c_ready;
`ifdef SYSTOLIC_MM_SAT_EN
   logic                    sat_flag;
`endif

   modport master (
      output in_valid, a_data, b_data, c_ready,
`ifdef SYSTOLIC_MM_SAT_EN
      input  sat_flag,
`endif
      input  in_ready, c_data, c_row, c_valid
   );

   modport slave (
      input  in_valid, a_data, b_data, c_ready,
`ifdef SYSTOLIC_MM_SAT_EN
      output sat_flag,
`endif
      output in_ready, c_data, c_row, c_valid
   );

endinterface

// File: rtl/mac_pe.sv
// mac_pe: one output-stationary processing element.
//   a_in/va_in -> a_out/va_out   operand and valid forwarded one column right
//   b_in/vb_in -> b_out/vb_out   operand and valid forwarded one row down
//   acc                          running sum of a*b for beats where both valids are set
//   clr                          zeroes accumulator and forwarded valids for a new job
//   sat                          sticky overflow flag, only with SYSTOLIC_MM_SAT_EN
// With SYSTOLIC_MM_SAT_EN each accumulate saturates; otherwise it wraps.
module mac_pe
   import systolic_mm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ACC_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic signed [WIDTH-1:0] a_in,
   input  logic signed [WIDTH-1:0] b_in,
   input  logic                    va_in,
   input  logic                    vb_in,
   output logic signed [WIDTH-1:0] a_out,
   output logic signed [WIDTH-1:0] b_out,
   output logic                    va_out,
   output logic                    vb_out,
   output logic signed [ACC_W-1:0] acc
`ifdef SYSTOLIC_MM_SAT_EN
   ,
   output logic                    sat
`endif
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_d;

   assign prod     = (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);
   assign prod_ext = ACC_W'(prod);

`ifdef SYSTOLIC_MM_SAT_EN
   sat_res_t sum_r;
   logic     sat_d;

   always_comb begin
      sum_r = sat_add(SAT_W'(acc), SAT_W'(prod_ext), ACC_W);
      acc_d = sum_r.sum[ACC_W-1:0];
      sat_d = sum_r.sat;
   end
`else
   always_comb begin
      acc_d = acc + prod_ext;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         a_out  <= '0;
         b_out  <= '0;
         va_out <= 1'b0;
         vb_out <= 1'b0;
         acc    <= '0;
`ifdef SYSTOLIC_MM_SAT_EN
         sat    <= 1'b0;
`endif
      end else begin
         a_out  <= a_in;
         b_out  <= b_in;
         va_out <= va_in;
         vb_out <= vb_in;
         if (va_in && vb_in) begin
            acc <= acc_d;
`ifdef SYSTOLIC_MM_SAT_EN
            sat <= sat | sat_d;
`endif
         end
      end
   end

endmodule

// File: rtl/systolic_mm.sv
// systolic_mm: output-stationary ROWS x COLS systolic matrix multiply, C = A*B.
//   clk, rst      clock, synchronous active-high reset
//   start, k_len  job start (IDLE only) and inner dimension, clamped to KMAX
//   bus           systolic_mm_if.slave: operand stream in, result rows out
//   busy, done    not-IDLE indicator; one-cycle pulse after the last row handshake
// Optional SYSTOLIC_MM_SAT_EN: saturating accumulators plus bus.sat_flag.
//
// state | meaning
// IDLE  | waiting for start; start clears accumulators and skew valids
// LOAD  | in_ready=1, accepting k_len operand beats (bubbles allowed)
// FLUSH | ROWS+COLS-1 cycles letting the last beat reach PE[ROWS-1][COLS-1]
// DRAIN | c_valid=1, presenting rows 0..ROWS-1 one per handshake
module systolic_mm
   import systolic_mm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int KMAX  = 256,
   parameter int ACC_W = default_acc_w(WIDTH, KMAX)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(KMAX+1)-1:0]  k_len,
   systolic_mm_if.slave               bus,
   output logic                       busy,
   output logic                       done
);

   localparam int KW = $clog2(KMAX + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int FW = $clog2(ROWS + COLS);

   state_t state_q, state_d;

   logic [KW-1:0]          k_q;
   logic [KW-1:0]          beat_q;
   logic [FW-1:0]          flush_q;
   logic [RW-1:0]          c_row_q;
   logic [COLS*ACC_W-1:0]  c_data_q;
   logic                   done_q;

   logic                   clr;
   logic                   fire;
   logic                   last_beat;
   logic                   load_row;
   logic                   done_d;
   logic [RW-1:0]          row_sel;
   logic [COLS*ACC_W-1:0]  row_vec;

   // Grid wiring: column index COLS / row index ROWS are the unused far edges.
   logic signed [WIDTH-1:0] a_h  [ROWS][COLS+1];
   logic                    va_h [ROWS][COLS+1];
   logic signed [WIDTH-1:0] b_v  [ROWS+1][COLS];
   logic                    vb_v [ROWS+1][COLS];
   logic signed [ACC_W-1:0] acc_a [ROWS][COLS];

   assign fire      = (state_q == LOAD) && bus.in_valid;
   assign last_beat = fire && (beat_q == k_q - KW'(1));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      clr      = 1'b0;
      load_row = 1'b0;
      row_sel  = '0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               clr     = 1'b1;
               state_d = (k_len == '0) ? DRAIN : LOAD;
            end
         end
         LOAD: begin
            if (last_beat) state_d = FLUSH;
         end
         FLUSH: begin
            if (flush_q == '0) begin
               state_d  = DRAIN;
               load_row = 1'b1;
            end
         end
         DRAIN: begin
            if (bus.c_ready) begin
               if (c_row_q == RW'(ROWS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  load_row = 1'b1;
                  row_sel  = c_row_q + RW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------ counters and result regs
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q      <= '0;
         beat_q   <= '0;
         flush_q  <= '0;
         c_row_q  <= '0;
         c_data_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= done_d;
         if (clr) begin
            k_q      <= (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
            beat_q   <= '0;
            c_row_q  <= '0;
            c_data_q <= '0;
         end
         if (fire) beat_q <= beat_q + KW'(1);
         if (last_beat)               flush_q <= FW'(ROWS + COLS - 2);
         else if (state_q == FLUSH)   flush_q <= flush_q - FW'(1);
         // Row 0 is captured on the last FLUSH edge; its PEs finished ROWS-1 edges earlier.
         if (load_row) begin
            c_row_q  <= row_sel;
            c_data_q <= row_vec;
         end
      end
   end

   always_comb begin
      row_vec = '0;
      for (int j = 0; j < COLS; j++) begin
         row_vec[j*ACC_W +: ACC_W] = acc_a[row_sel][j];
      end
   end

   assign bus.in_ready = (state_q == LOAD);
   assign bus.c_valid  = (state_q == DRAIN);
   assign bus.c_row    = c_row_q;
   assign bus.c_data   = c_data_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;

   // --------------------------------------------------------------- skew
   // Lane i sees one input register plus i skew stages, so a beat accepted at
   // cycle t reaches PE[i][j] during cycle t+1+i+j.
   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      logic signed [WIDTH-1:0] sr [i+1];
      logic                    vr [i+1];
      always_ff @(posedge clk) begin
         if (rst || clr) begin
            for (int k = 0; k <= i; k++) begin
               sr[k] <= '0;
               vr[k] <= 1'b0;
            end
         end else begin
            sr[0] <= bus.a_data[i*WIDTH +: WIDTH];
            vr[0] <= fire;
            for (int k = 1; k <= i; k++) begin
               sr[k] <= sr[k-1];
               vr[k] <= vr[k-1];
            end
         end
      end
      assign a_h[i][0]  = sr[i];
      assign va_h[i][0] = vr[i];
   end

   for (genvar j = 0; j < COLS; j++) begin : g_b_skew
      logic signed [WIDTH-1:0] sr [j+1];
      logic                    vr [j+1];
      always_ff @(posedge clk) begin
         if (rst || clr) begin
            for (int k = 0; k <= j; k++) begin
               sr[k] <= '0;
               vr[k] <= 1'b0;
            end
         end else begin
            sr[0] <= bus.b_data[j*WIDTH +: WIDTH];
            vr[0] <= fire;
            for (int k = 1; k <= j; k++) begin
               sr[k] <= sr[k-1];
               vr[k] <= vr[k-1];
            end
         end
      end
      assign b_v[0][j]  = sr[j];
      assign vb_v[0][j] = vr[j];
   end

   // --------------------------------------------------------------- grid
`ifdef SYSTOLIC_MM_SAT_EN
   logic pe_sat [ROWS][COLS];
   logic sat_any;

   always_comb begin
      sat_any = 1'b0;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLS; j++) begin
            sat_any = sat_any | pe_sat[i][j];
         end
      end
   end

   assign bus.sat_flag = sat_any;
`endif

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         mac_pe #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
         ) u_pe (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .a_in   (a_h[i][j]),
            .b_in   (b_v[i][j]),
            .va_in  (va_h[i][j]),
            .vb_in  (vb_v[i][j]),
            .a_out  (a_h[i][j+1]),
            .b_out  (b_v[i+1][j]),
            .va_out (va_h[i][j+1]),
            .vb_out (vb_v[i+1][j]),
            .acc    (acc_a[i][j])
`ifdef SYSTOLIC_MM_SAT_EN
            ,
            .sat    (pe_sat[i][j])
`endif
         );
      end
   end

endmodule

// File: tb/tb_systolic_mm.sv
// tb_systolic_mm: directed bench for a 2x2, 8-bit, KMAX=8, ACC_W=16 systolic_mm.
// Expected results are hand-computed constants set before each job.
module tb_systolic_mm;

   localparam int WIDTH = 8;
   localparam int ROWS  = 2;
   localparam int COLS  = 2;
   localparam int KMAX  = 8;
   localparam int ACC_W = 16;
   localparam int KW    = $clog2(KMAX + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          busy;
   logic          done;

   int n_chk     = 0;
   int n_pass    = 0;
   int cyc       = 0;
   int start_cyc = 0;
   int n_acc     = 0;

   logic [ROWS*WIDTH-1:0] a_beats [8];
   logic [COLS*WIDTH-1:0] b_beats [8];
   int                    exp_c   [ROWS][COLS];
   logic                  exp_sat;

   systolic_mm_if #(
      .WIDTH (WIDTH), .ROWS (ROWS), .COLS (COLS), .KMAX (KMAX), .ACC_W (ACC_W)
   ) bus ();

   systolic_mm #(
      .WIDTH (WIDTH), .ROWS (ROWS), .COLS (COLS), .KMAX (KMAX), .ACC_W (ACC_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .k_len (k_len),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pk(input int lo, input int hi);
      return {hi[7:0], lo[7:0]};
   endfunction

   task automatic set_exp(input int c00, input int c01, input int c10, input int c11);
      exp_c[0][0] = c00;
      exp_c[0][1] = c01;
      exp_c[1][0] = c10;
      exp_c[1][1] = c11;
   endtask

   task automatic begin_job(input int k);
      k_len = KW'(k);
      start = 1'b1;
      tick();
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   // Presents n beats; gap idle (bubble) cycles precede every beat after the first.
   task automatic feed(input int n, input int gap);
      for (int b = 0; b < n; b++) begin
         if (b > 0) repeat (gap) tick();
         bus.a_data   = a_beats[b];
         bus.b_data   = b_beats[b];
         bus.in_valid = 1'b1;
         chk("in_ready_load", bus.in_ready, 1'b1);
         tick();
         bus.in_valid = 1'b0;
      end
      chk("in_ready_flush", bus.in_ready, 1'b0);
   endtask

   // Waits for the result stream, checks latency (lat<0 skips), rows, optional
   // c_ready stall on row 0 with start held high, and the done pulse.
   task automatic drain(input int lat, input int stall);
      int guard;
      guard = 0;
      while (!bus.c_valid && guard < 40) begin
         tick();
         guard++;
      end
      chk("c_valid_rise", bus.c_valid, 1'b1);
      if (lat >= 0) chk("latency", cyc - start_cyc, lat);
`ifdef SYSTOLIC_MM_SAT_EN
      chk("sat_flag", bus.sat_flag, exp_sat);
`endif
      for (int r = 0; r < ROWS; r++) begin
         chk("c_row", bus.c_row, r);
         for (int j = 0; j < COLS; j++)
            chk("c_data", $signed(bus.c_data[j*ACC_W +: ACC_W]), exp_c[r][j]);
         if (r == 0) begin
            for (int s = 0; s < stall; s++) begin
               bus.c_ready = 1'b0;
               start       = 1'b1;
               tick();
               chk("stall_valid", bus.c_valid, 1'b1);
               chk("stall_row", bus.c_row, 0);
               for (int j = 0; j < COLS; j++)
                  chk("stall_data", $signed(bus.c_data[j*ACC_W +: ACC_W]), exp_c[0][j]);
            end
            start = 1'b0;
         end
         chk("done_early", done, 1'b0);
         bus.c_ready = 1'b1;
         tick();
         bus.c_ready = 1'b0;
      end
      chk("done_pulse", done, 1'b1);
      chk("busy_idle", busy, 1'b0);
      tick();
      chk("done_clear", done, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      k_len        = '0;
      bus.in_valid = 1'b0;
      bus.c_ready  = 1'b0;
      bus.a_data   = '0;
      bus.b_data   = '0;
      exp_sat      = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_c_valid", bus.c_valid, 1'b0);
      chk("rst_c_row", bus.c_row, 0);
      chk("rst_c_data", bus.c_data, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      rst = 1'b0;
      tick();

      // Basic 2x2, K=2 job.
      a_beats[0] = pk(1, 3);  b_beats[0] = pk(5, 6);
      a_beats[1] = pk(2, 4);  b_beats[1] = pk(7, 8);
      set_exp(19, 22, 43, 50);
      begin_job(2);
      chk("busy_load", busy, 1'b1);
      feed(2, 0);
      drain(5, 0);

      // Same job with a bubble between beats: one cycle later.
      begin_job(2);
      feed(2, 1);
      drain(6, 0);

      // Row 0 held for 5 cycles with start asserted (must be ignored).
      begin_job(2);
      feed(2, 0);
      drain(5, 5);

      // k_len = 0: straight to DRAIN with zero rows.
      set_exp(0, 0, 0, 0);
      begin_job(0);
      drain(0, 0);

      // Abort during FLUSH, with start coincident with rst.
      set_exp(19, 22, 43, 50);
      begin_job(2);
      feed(2, 0);
      tick();
      chk("flush_busy", busy, 1'b1);
      rst   = 1'b1;
      start = 1'b1;
      k_len = KW'(1);
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_c_valid", bus.c_valid, 1'b0);
      repeat (4) tick();
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle", busy, 1'b0);

      // Fresh job after abort: (-1)*(-1) everywhere.
      a_beats[0] = pk(-1, -1);  b_beats[0] = pk(-1, -1);
      set_exp(1, 1, 1, 1);
      begin_job(1);
      feed(1, 0);
      drain(4, 0);

      // k_len=12 is clamped to KMAX=8 beats.
      set_exp(8, 8, 8, 8);
      begin_job(12);
      bus.a_data   = pk(1, 1);
      bus.b_data   = pk(1, 1);
      bus.in_valid = 1'b1;
      n_acc        = 0;
      for (int c = 0; c < 16; c++) begin
         if (bus.in_ready) n_acc++;
         tick();
      end
      bus.in_valid = 1'b0;
      chk("clamp_beats", n_acc, 8);
      drain(-1, 0);

      // Overflow: K=4, all operands 127, ACC_W=16.
      for (int b = 0; b < 4; b++) begin
         a_beats[b] = pk(127, 127);
         b_beats[b] = pk(127, 127);
      end
`ifdef SYSTOLIC_MM_SAT_EN
      set_exp(32767, 32767, 32767, 32767);
      exp_sat = 1'b1;
`else
      set_exp(-1020, -1020, -1020, -1020);
`endif
      begin_job(4);
      feed(4, 0);
      drain(7, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
